// File: rtl/mux_rr_pkg.sv
// Shared definitions for the round-robin arbitrated 16:1 mux: FSM encoding and
// default sizing for N_REQ, SEL_W and HOLD_MAX.
package mux_rr_pkg;

  localparam int N_REQ_DEF    = 16;
  localparam int SEL_W_DEF    = 4;
  localparam int HOLD_MAX_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotating priority encoder. Returns the first set req
// bit found searching upward from last+1, wrapping at N_REQ-1.
module rr_pick #(
  parameter int N_REQ = 16,
  parameter int SEL_W = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] pos;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      pos = SEL_W'((int'(last) + k) % N_REQ);
      if (req[pos]) begin
        idx = pos;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter steering one requester's din bit onto y. Optional hold
// limit with forced release enabled by defining MUX_RR_ARBITER_TIMEOUT_EN.
module mux_rr_arbiter
  import mux_rr_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] din,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             gnt_valid,
  output logic             y,
  output logic             timeout
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [N_REQ-1:0] grant_d;
  logic             gv_d;
  logic             y_d;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic             hold_hit;

  rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req  (req),
    .last (last_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel;
    grant_d = grant;
    gv_d    = gnt_valid;
    y_d     = y;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        gv_d    = 1'b0;
        if (pick_any) begin
          state_d           = BUSY;
          sel_d             = pick_idx;
          grant_d[pick_idx] = 1'b1;
          gv_d              = 1'b1;
        end
      end
      BUSY: begin
        y_d = din[sel];
        // A release edge always returns to IDLE, so a new owner waits one cycle.
        if (!req[sel] || hold_hit) begin
          state_d = IDLE;
          grant_d = '0;
          gv_d    = 1'b0;
          last_d  = sel;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel       <= '0;
      grant     <= '0;
      gnt_valid <= 1'b0;
      y         <= 1'b0;
      last_q    <= SEL_W'(N_REQ - 1);
    end else begin
      state_q   <= state_d;
      sel       <= sel_d;
      grant     <= grant_d;
      gnt_valid <= gv_d;
      y         <= y_d;
      last_q    <= last_d;
    end
  end

`ifdef MUX_RR_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  logic [CNT_W-1:0] hold_q;

  assign hold_hit = (hold_q == CNT_W'(HOLD_MAX - 1));

  // The pulse only fires when the owner still wants the bus; a coincident
  // voluntary release wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= (state_q == BUSY) && req[sel] && hold_hit;
      hold_q  <= (state_q == BUSY && state_d == BUSY) ? hold_q + 1'b1 : '0;
    end
  end
`else
  assign hold_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

endmodule
